// File: rtl/msg_pkg.sv
// -----------------------------------------------------------------------------
// msg_pkg
// Shared definitions for the message streamer:
//   ADDR_W   - character ROM address width
//   DATA_W   - character width
//   CHAR_NUL - terminator character that ends a message
//   state_t  - streamer FSM state encoding
// -----------------------------------------------------------------------------
package msg_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] CHAR_NUL = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/msg_streamer.sv
// -----------------------------------------------------------------------------
// msg_streamer
// Walks a NUL-terminated message stored in an external combinational-read
// character ROM and hands each character to a downstream sink through a
// valid/ready handshake. One character every two cycles when the sink is
// always ready (FETCH cycle + SEND cycle).
//
// Parameters:
//   START_ADDR - first ROM address read by each pass
//   LAST_ADDR  - highest ROM address read before the pass is forced to end
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst        - synchronous active-high reset
//   start      - begin a pass (only looked at while idle)
//   abort      - cancel the current pass, highest priority after rst
//   rom_addr   - address to the character ROM
//   rom_data   - ROM character for rom_addr, valid in the same cycle
//   out_data   - character presented to the sink
//   out_valid  - out_data holds a character
//   out_ready  - sink accepts out_data this cycle
//   busy       - high in every state except IDLE
//   done       - one-cycle pulse at the end of a pass
//
// Build option:
//   MSG_STREAMER_LOOP_EN - when defined, the end of a pass pulses done and
//   immediately restarts from START_ADDR, repeating until abort or rst.
//   When undefined, each start produces a single pass.
// -----------------------------------------------------------------------------
module msg_streamer
    import msg_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR = 6'd1,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = 6'd63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_t              state_reg;
    logic [ADDR_W-1:0]   rom_addr_reg;
    logic [DATA_W-1:0]   out_data_reg;
    logic                out_valid_reg;
    logic                busy_reg;
    logic                done_reg;

    logic                handshake;
    logic                at_last;

    assign handshake = out_valid_reg && out_ready;

    // ">=" rather than "==" so that a START_ADDR above LAST_ADDR still ends
    // the pass on the first delivered character instead of running on
    // through the address space. The address never wraps back to 0.
    assign at_last = (rom_addr_reg >= LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rom_addr_reg  <= '0;
            out_data_reg  <= CHAR_NUL;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else if (abort) begin
            // Also covers start+abort in IDLE: abort wins and we stay idle.
            // A character that handshakes in this cycle has already been
            // taken by the sink, so dropping valid here loses nothing.
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        rom_addr_reg <= START_ADDR;
                        busy_reg     <= 1'b1;
                        state_reg    <= FETCH;
                    end
                end

                FETCH: begin
                    // rom_data already reflects rom_addr_reg this cycle.
                    if (rom_data == CHAR_NUL) begin
                        done_reg  <= 1'b1;
                        state_reg <= FINISH;
                    end else begin
                        out_data_reg  <= rom_data;
                        out_valid_reg <= 1'b1;
                        state_reg     <= SEND;
                    end
                end

                SEND: begin
                    // out_data/out_valid hold until the sink takes the character.
                    if (handshake) begin
                        out_valid_reg <= 1'b0;
                        if (at_last) begin
                            done_reg  <= 1'b1;
                            state_reg <= FINISH;
                        end else begin
                            rom_addr_reg <= rom_addr_reg + ADDR_W'(1);
                            state_reg    <= FETCH;
                        end
                    end
                end

                FINISH: begin
                    done_reg <= 1'b0;
`ifdef MSG_STREAMER_LOOP_EN
                    rom_addr_reg <= START_ADDR;
                    state_reg    <= FETCH;
`else
                    // rom_addr is left pointing at the terminating address.
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
`endif
                end

                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr  = rom_addr_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
